// File: rtl/mem_access_unit.sv
// Load/store front end for the 1024x32 data RAM: turns byte/half/word accesses into
// word-wide RAM cycles with sign/zero extension, read-modify-write and alignment checks.
module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              io_clk,
    input  logic              io_reset,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic              io_req_we,
    input  logic [1:0]        io_req_size,
    input  logic              io_req_signed,
    input  logic [31:0]       io_req_addr,
    input  logic [31:0]       io_req_wdata,
    output logic              io_resp_valid,
    output logic [31:0]       io_resp_rdata,
    output logic              io_resp_err,
    output logic              io_ram_we,
    output logic [ADDR_W-1:0] io_ram_addra,
    output logic [31:0]       io_ram_dina,
    input  logic [31:0]       io_ram_douta
);

    typedef enum logic [2:0] {IDLE, RD0, RD1, WR, RESP} state_t;

    state_t      state, state_nxt;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [1:0]  lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] word_q;
    logic        accept;
    logic        req_err;
    logic [31:0] load_result;
    logic [31:0] merged_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Address bits above the RAM word address alias onto the same word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^io_req_addr[31:ADDR_W+2];

    assign accept = (state == IDLE) && io_req_valid;

    always_comb begin
        req_err = 1'b0;
        case (io_req_size)
            2'b01:   req_err = io_req_addr[0];
            2'b10:   req_err = |io_req_addr[1:0];
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
    end

    // Load data is taken straight from the RAM port in RD1, the cycle it becomes valid.
    always_comb begin
        byte_sel    = io_ram_douta[{lat_addr, 3'b000} +: 8];
        half_sel    = io_ram_douta[{lat_addr[1], 4'b0000} +: 16];
        load_result = io_ram_douta;
        case (lat_size)
            2'b00:   load_result = {{24{lat_signed & byte_sel[7]}}, byte_sel};
            2'b01:   load_result = {{16{lat_signed & half_sel[15]}}, half_sel};
            default: load_result = io_ram_douta;
        endcase
    end

    always_comb begin
        merged_word = word_q;
        case (lat_size)
            2'b00:   merged_word[{lat_addr, 3'b000} +: 8] = lat_wdata[7:0];
            2'b01:   merged_word[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
            default: merged_word = lat_wdata;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        io_req_ready  = 1'b0;
        io_resp_valid = 1'b0;
        io_ram_we     = 1'b0;
        io_ram_dina   = '0;
        case (state)
            IDLE: begin
                io_req_ready = 1'b1;
                if (io_req_valid) begin
                    if (req_err)
                        state_nxt = RESP;
                    else if (io_req_we && io_req_size == 2'b10)
                        state_nxt = WR;
                    else
                        state_nxt = RD0;
                end
            end
            RD0:  state_nxt = RD1;
            RD1:  state_nxt = lat_we ? WR : RESP;
            WR: begin
                io_ram_we   = 1'b1;
                io_ram_dina = merged_word;
                state_nxt   = RESP;
            end
            RESP: begin
                io_resp_valid = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The RAM address is loaded once at accept and simply held through RD0/RD1/WR.
    always_ff @(posedge io_clk) begin
        if (!io_reset) begin
            state         <= IDLE;
            lat_we        <= 1'b0;
            lat_size      <= '0;
            lat_signed    <= 1'b0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            word_q        <= '0;
            io_resp_rdata <= '0;
            io_resp_err   <= 1'b0;
            io_ram_addra  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_we      <= io_req_we;
                lat_size    <= io_req_size;
                lat_signed  <= io_req_signed;
                lat_addr    <= io_req_addr[1:0];
                lat_wdata   <= io_req_wdata;
                io_resp_err <= req_err;
                if (!req_err)
                    io_ram_addra <= io_req_addr[ADDR_W+1:2];
            end
            if (state == RD1) begin
                word_q <= io_ram_douta;
                if (!lat_we)
                    io_resp_rdata <= load_result;
            end
            if (state == RESP) begin
                io_resp_rdata <= '0;
                io_resp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random traffic
// compared against a word-array reference model of the data memory.
module tb_mem_access_unit;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready, req_we, req_signed;
    logic [1:0]        req_size;
    logic [31:0]       req_addr, req_wdata;
    logic              resp_valid, resp_err;
    logic [31:0]       resp_rdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addra;
    logic [31:0]       ram_dina, ram_douta;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .io_clk(clk), .io_reset(rst_n),
        .io_req_valid(req_valid), .io_req_ready(req_ready), .io_req_we(req_we),
        .io_req_size(req_size), .io_req_signed(req_signed), .io_req_addr(req_addr),
        .io_req_wdata(req_wdata), .io_resp_valid(resp_valid), .io_resp_rdata(resp_rdata),
        .io_resp_err(resp_err), .io_ram_we(ram_we), .io_ram_addra(ram_addra),
        .io_ram_dina(ram_dina), .io_ram_douta(ram_douta)
    );

    // Synchronous-read RAM standing in for the data RAM wrapper.
    logic [31:0] ram [0:DEPTH-1];
    logic        ram_init = 1'b1;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
            ram_douta <= '0;
        end else begin
            if (ram_we) ram[ram_addra] <= ram_dina;
            ram_douta <= ram[ram_addra];
        end
    end

    logic [31:0] ref_mem [0:DEPTH-1];

    logic [31:0] obs_rdata, obs_wdata, exp_rdata, exp_wdata;
    logic        obs_err, exp_err;
    logic [9:0]  obs_waddr, exp_idx;
    int          obs_lat, obs_nwr, obs_busy_ready, exp_lat, exp_writes;

    task automatic model_access(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata);
        int          idx;
        int          off;
        logic [31:0] w, v, mask;
        idx = int'((addr >> 2) % DEPTH);
        off = int'(addr % 32'd4);
        exp_idx    = 10'(idx);
        exp_err    = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0);
        exp_rdata  = '0;
        exp_writes = 0;
        exp_wdata  = '0;
        if (exp_err) begin
            exp_lat = 1;
            return;
        end
        w = ref_mem[idx];
        if (!we) begin
            exp_lat = 3;
            if (size == 2'd0) begin
                v = (w >> (8 * off)) & 32'hFF;
                if (sgn && v > 32'd127) v = v + 32'hFFFFFF00;
            end else if (size == 2'd1) begin
                v = (w >> (8 * off)) & 32'hFFFF;
                if (sgn && v > 32'd32767) v = v + 32'hFFFF0000;
            end else begin
                v = w;
            end
            exp_rdata = v;
        end else begin
            if (size == 2'd2) begin
                exp_lat = 2;
                v = wdata;
            end else begin
                exp_lat = 4;
                mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
                v = (w & ~mask) | ((wdata << (8 * off)) & mask);
            end
            ref_mem[idx] = v;
            exp_writes   = 1;
            exp_wdata    = v;
        end
    endtask

    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
        obs_rdata = '0; obs_err = 1'b0; obs_lat = -1; obs_nwr = 0;
        obs_wdata = '0; obs_waddr = '0; obs_busy_ready = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (req_ready) obs_busy_ready++;
            if (ram_we) begin
                obs_nwr++;
                obs_wdata = ram_dina;
                obs_waddr = ram_addra;
            end
            if (resp_valid) begin
                obs_rdata = resp_rdata;
                obs_err   = resp_err;
                obs_lat   = k;
                break;
            end
        end
    endtask

    task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
        model_access(we, size, sgn, addr, wdata);
        run_req(we, size, sgn, addr, wdata);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (ram_we !== 1'b0) begin fails++; $display("[TB] FAIL reset_ram_we: got %b expected 0", ram_we); end
        checks++; if (ram_addra !== 10'd0) begin fails++; $display("[TB] FAIL reset_ram_addra: got %h expected 0", ram_addra); end
        checks++; if (resp_rdata !== 32'd0 || resp_err !== 1'b0 || ram_dina !== 32'd0) begin
            fails++; $display("[TB] FAIL reset_data: rdata %h err %b dina %h expected all 0", resp_rdata, resp_err, ram_dina);
        end
        ram_init = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_word_store_load();
        xact(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF);
        checks++; if (obs_nwr !== 1 || obs_waddr !== 10'd4 || obs_wdata !== 32'hDEADBEEF) begin
            fails++; $display("[TB] FAIL word_store_write: writes %0d addr %h data %h expected 1/004/deadbeef", obs_nwr, obs_waddr, obs_wdata);
        end
        checks++; if (obs_lat !== 2 || obs_err !== 1'b0) begin
            fails++; $display("[TB] FAIL word_store_resp: latency %0d err %b expected 2/0", obs_lat, obs_err);
        end
        xact(1'b0, 2'd2, 1'b0, 32'h010, 32'h0);
        checks++; if (obs_rdata !== 32'hDEADBEEF || obs_lat !== 3) begin
            fails++; $display("[TB] FAIL word_load: rdata %h latency %0d expected deadbeef/3", obs_rdata, obs_lat);
        end
    endtask

    task automatic test_byte_loads();
        logic [31:0] addrs [4] = '{32'h013, 32'h013, 32'h010, 32'h012};
        logic [1:0]  sizes [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        sgns  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, sizes[i], sgns[i], addrs[i], 32'h0);
            checks++; if (obs_rdata !== exps[i] || obs_lat !== 3 || obs_err !== 1'b0) begin
                fails++; $display("[TB] FAIL subword_load_%0d: rdata %h latency %0d err %b expected %h/3/0", i, obs_rdata, obs_lat, obs_err, exps[i]);
            end
        end
    endtask

    task automatic test_subword_stores();
        xact(1'b1, 2'd0, 1'b0, 32'h011, 32'hAAAAAA55);
        checks++; if (obs_wdata !== 32'hDEAD55EF || obs_nwr !== 1 || obs_lat !== 4) begin
            fails++; $display("[TB] FAIL byte_store: dina %h writes %0d latency %0d expected dead55ef/1/4", obs_wdata, obs_nwr, obs_lat);
        end
        xact(1'b0, 2'd2, 1'b0, 32'h010, 32'h0);
        checks++; if (obs_rdata !== 32'hDEAD55EF) begin
            fails++; $display("[TB] FAIL byte_store_readback: got %h expected dead55ef", obs_rdata);
        end
        xact(1'b1, 2'd1, 1'b0, 32'h012, 32'hFFFF1234);
        checks++; if (obs_wdata !== 32'h123455EF || obs_waddr !== 10'd4 || obs_lat !== 4) begin
            fails++; $display("[TB] FAIL half_store: dina %h addr %h latency %0d expected 123455ef/004/4", obs_wdata, obs_waddr, obs_lat);
        end
    endtask

    task automatic test_errors();
        logic        wes   [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  sizes [3] = '{2'd2, 2'd1, 2'd3};
        logic [31:0] addrs [3] = '{32'h012, 32'h001, 32'h010};
        for (int i = 0; i < 3; i++) begin
            xact(wes[i], sizes[i], 1'b1, addrs[i], 32'hCAFEF00D);
            checks++; if (obs_err !== 1'b1 || obs_rdata !== 32'd0 || obs_lat !== 1 || obs_nwr !== 0) begin
                fails++; $display("[TB] FAIL error_%0d: err %b rdata %h latency %0d writes %0d expected 1/0/1/0", i, obs_err, obs_rdata, obs_lat, obs_nwr);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          busy_ready = 0;
        int          resp_a = -1, resp_b = -1;
        logic [31:0] rd_a = '0, rd_b = '0;
        logic        ready_gap = 1'b0;
        logic [9:0]  addr_b = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h010; req_wdata = '0;
        @(posedge clk);
        #1 req_addr = 32'h1010;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 3 && req_ready) busy_ready++;
            if (resp_valid && resp_a < 0) begin resp_a = k; rd_a = resp_rdata; end
            if (k == 4) ready_gap = req_ready && !resp_valid;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) addr_b = ram_addra;
            if (!resp_valid && req_ready) busy_ready++;
            if (resp_valid) begin resp_b = k; rd_b = resp_rdata; break; end
        end
        checks++; if (busy_ready !== 0) begin fails++; $display("[TB] FAIL handshake_ready_busy: ready high %0d busy cycles expected 0", busy_ready); end
        checks++; if (resp_a !== 3 || rd_a !== 32'h123455EF) begin
            fails++; $display("[TB] FAIL handshake_first: latency %0d rdata %h expected 3/123455ef", resp_a, rd_a);
        end
        checks++; if (ready_gap !== 1'b1) begin fails++; $display("[TB] FAIL handshake_idle_gap: got %b expected 1", ready_gap); end
        checks++; if (resp_b !== 3 || rd_b !== 32'h123455EF || addr_b !== 10'd4) begin
            fails++; $display("[TB] FAIL handshake_alias: latency %0d rdata %h addr %h expected 3/123455ef/004", resp_b, rd_b, addr_b);
        end
    endtask

    task automatic test_reset_midop();
        int pulses = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h010; req_wdata = '0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || ram_addra !== 10'd0) begin
            fails++; $display("[TB] FAIL reset_midop_idle: ready %b addr %h expected 1/000", req_ready, ram_addra);
        end
        if (resp_valid) pulses++;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        checks++; if (pulses !== 0) begin fails++; $display("[TB] FAIL reset_midop_no_resp: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_random();
        logic        we, sgn;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
        for (int i = 0; i < 60; i++) begin
            we    = 1'($urandom);
            sgn   = 1'($urandom);
            size  = 2'($urandom_range(0, 3));
            addr  = $urandom & 32'h0000_303F;
            wdata = $urandom;
            xact(we, size, sgn, addr, wdata);
            checks++; if (obs_err !== exp_err || obs_lat !== exp_lat) begin
                fails++; $display("[TB] FAIL rand_%0d_status: err %b latency %0d expected %b/%0d", i, obs_err, obs_lat, exp_err, exp_lat);
            end
            checks++; if (obs_rdata !== exp_rdata) begin
                fails++; $display("[TB] FAIL rand_%0d_rdata: got %h expected %h", i, obs_rdata, exp_rdata);
            end
            checks++; if (obs_nwr !== exp_writes || obs_busy_ready !== 0) begin
                fails++; $display("[TB] FAIL rand_%0d_writes: writes %0d ready_busy %0d expected %0d/0", i, obs_nwr, obs_busy_ready, exp_writes);
            end
            if (exp_writes == 1) begin
                checks++; if (obs_wdata !== exp_wdata || obs_waddr !== exp_idx) begin
                    fails++; $display("[TB] FAIL rand_%0d_wdata: dina %h addr %h expected %h/%h", i, obs_wdata, obs_waddr, exp_wdata, exp_idx);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        test_reset();
        test_reset_midop();
        test_word_store_load();
        test_byte_loads();
        test_subword_stores();
        test_errors();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not complete, %0d checks done", checks);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the multi-cycle CPU's load/store datapath and the 1024x32 data RAM wrapper. Drives that wrapper's write enable, 10-bit word address and write data, and consumes its read data.
- Converts byte, halfword and word loads/stores into word-wide RAM operations:
  - sign/zero extension on loads;
  - read-modify-write for sub-word stores;
  - misalignment detection.
- Uses a valid/ready request and a single-cycle response pulse.

Parameters:
- ADDR_W, 10, RAM word-address width; the word address is byte address bits [ADDR_W+1:2].

Ports:
- io_clk, in, 1, system clock.
- io_reset, in, 1, synchronous active-low reset.
- io_req_valid, in, 1, request present.
- io_req_ready, out, 1, unit can accept; high only in IDLE.
- io_req_we, in, 1, 1 = store, 0 = load.
- io_req_size, in, 2, 00 byte, 01 half, 10 word, 11 reserved.
- io_req_signed, in, 1, sign-extend load result.
- io_req_addr, in, 32, byte address.
- io_req_wdata, in, 32, store data; low byte/half used for sub-word stores.
- io_resp_valid, out, 1, one-cycle completion pulse.
- io_resp_rdata, out, 32, load result; 0 for stores and errors.
- io_resp_err, out, 1, misaligned or reserved size; qualified by io_resp_valid.
- io_ram_we, out, 1, RAM write enable.
- io_ram_addra, out, ADDR_W, RAM word address.
- io_ram_dina, out, 32, RAM write data.
- io_ram_douta, in, 32, RAM read data; valid the cycle after io_ram_addra is presented.

Behaviour:
- Reset:
  - io_reset==0 at a rising edge gives state=IDLE and clears all internal registers.
  - Outputs after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_we=0, ram_addra=0, ram_dina=0.
  - Reset mid-operation abandons the request and issues no response.
  - A RAM write already asserted in the cycle reset is sampled is not suppressed retroactively.
- Accept: in IDLE, req_valid&&req_ready at a rising edge latches we/size/signed/addr/wdata. Request inputs are ignored in all other states.
- Error check at accept: any of the following goes IDLE->RESP with err=1, no RAM access, and rdata=0:
  - size==11;
  - size==01 && addr[0];
  - size==10 && addr[1:0]!=0.
- States: IDLE, RD0, RD1, WR, RESP.
  - Load: IDLE->RD0->RD1->RESP->IDLE.
  - Word store: IDLE->WR->RESP->IDLE.
  - Byte/half store: IDLE->RD0->RD1->WR->RESP->IDLE.
  - Error: IDLE->RESP->IDLE.
- RAM drive:
  - ram_addra = latched addr[ADDR_W+1:2] in RD0, RD1 and WR; otherwise holds its last value.
  - Address bits above ADDR_W+1 are ignored (addresses alias).
  - ram_we=1 only in WR.
  - ram_dina is valid in WR.
- RD1 captures io_ram_douta into an internal word register at the end of the cycle.
- Byte lanes are little-endian: byte k = bits [8k+7:8k]; halfword at addr[1] = bits [16*addr[1]+15:16*addr[1]].
- Load extraction (registered into resp_rdata when entering RESP):
  - the selected byte/half is zero-extended, or sign-extended when signed=1;
  - a word load returns the full word; signed is ignored for words.
- Store merge in WR:
  - the captured word has only the selected lane replaced by wdata[7:0] or wdata[15:0];
  - a word store writes wdata unmodified.
- RESP:
  - resp_valid=1 for exactly one cycle;
  - resp_err and resp_rdata are valid only in that cycle and return to 0 in IDLE.
- No response backpressure; the consumer must take the pulse.
- Latency from accept edge to resp_valid:
  - load 3 cycles;
  - sub-word store 4 cycles;
  - word store 2 cycles;
  - error 1 cycle.
- req_ready returns high in the cycle after RESP, so back-to-back requests are spaced by at least one IDLE cycle.

Test Plan:
- Reset:
  - Hold io_reset=0 for 2 cycles -> req_ready=1, resp_valid=0, ram_we=0, ram_addra=0.
  - Assert reset during RD1 of a load -> IDLE next cycle and no resp_valid pulse.
- Word store then load:
  - Store 0xDEADBEEF at 0x010 -> ram_we=1 for one cycle with addra=4, dina=0xDEADBEEF; resp_valid 2 cycles after accept with err=0.
  - Word load from 0x010 -> rdata=0xDEADBEEF 3 cycles after accept.
- Byte loads (word 4 = 0xDEADBEEF):
  - Signed byte at 0x013 -> 0xFFFFFFDE.
  - Unsigned byte at 0x013 -> 0x000000DE.
  - Signed half at 0x010 -> 0xFFFFBEEF.
  - Unsigned half at 0x012 -> 0x0000DEAD.
- Sub-word stores:
  - Byte store 0x55 at 0x011 -> RD0, RD1, then WR with dina=0xDEAD55EF; a following word load returns 0xDEAD55EF.
  - Half store 0x1234 at 0x012 -> dina=0x123455EF.
- Errors:
  - Word load at 0x012 -> resp_err=1, rdata=0, 1 cycle after accept, ram_we never asserted.
  - Half store at 0x001 -> resp_err=1 and no RAM write.
  - size=11 -> resp_err=1.
- Handshake: hold req_valid high with two queued requests -> second accepted only after the RESP cycle; req_ready is 0 in RD0/RD1/WR/RESP; address 0x1010 aliases to word 4.
